// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with branch redirect, squash bubble, start/halt
module pc_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_halt,
    input  logic                i_fetch_ready,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_pc,
    input  logic [7:0]          i_offset,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_fetch_valid,
    output logic                o_flush,
    output logic                o_running,
    output logic [7:0]          o_branch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [7:0]          r_branch_count;
    logic [7:0]          w_branch_count_next;
    logic                r_fetch_valid;
    logic                r_flush;
    logic                r_running;

    logic signed [7:0]   w_offset_s;
    logic [PC_WIDTH-1:0] w_offset_ext;
    logic [PC_WIDTH-1:0] w_target;

    // A signed size cast sign-extends for wide PCs and truncates for narrow ones.
    assign w_offset_s   = i_offset;
    assign w_offset_ext = PC_WIDTH'(w_offset_s);
    assign w_target     = i_branch_pc + w_offset_ext;

    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_branch_count_next = r_branch_count;
        case (r_state)
            S_IDLE: begin
                if (i_halt)
                    w_state_next = S_HALT;
                else if (i_start)
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                if (i_halt) begin
                    w_state_next = S_HALT;
                end else if (i_branch_taken) begin
                    w_state_next = S_FLUSH;
                    w_pc_next    = w_target;
                    if (r_branch_count != 8'hFF)
                        w_branch_count_next = r_branch_count + 8'd1;
                end else if (i_fetch_ready) begin
                    w_pc_next = r_pc + PC_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                w_state_next = i_halt ? S_HALT : S_RUN;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_branch_count <= 8'd0;
            r_fetch_valid  <= 1'b0;
            r_flush        <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_branch_count <= w_branch_count_next;
            r_fetch_valid  <= (w_state_next == S_RUN);
            r_flush        <= (w_state_next == S_FLUSH);
            r_running      <= (w_state_next == S_RUN) || (w_state_next == S_FLUSH);
        end
    end

    assign o_pc           = r_pc;
    assign o_fetch_valid  = r_fetch_valid;
    assign o_flush        = r_flush;
    assign o_running      = r_running;
    assign o_branch_count = r_branch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    typedef struct packed {
        logic [7:0] pc;
        logic       fv;
        logic       fl;
        logic       run;
        logic [7:0] cnt;
    } obs_t;

    typedef struct packed {
        logic       start;
        logic       halt;
        logic       fr;
        logic       bt;
        logic [7:0] bpc;
        logic [7:0] off;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       fetch_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_pc = 8'h00;
    logic [7:0] offset = 8'h00;
    logic [7:0] pc;
    logic       fetch_valid;
    logic       flush;
    logic       running;
    logic [7:0] branch_count;

    int   n_checks = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    pc_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_halt         (halt),
        .i_fetch_ready  (fetch_ready),
        .i_branch_taken (branch_taken),
        .i_branch_pc    (branch_pc),
        .i_offset       (offset),
        .o_pc           (pc),
        .o_fetch_valid  (fetch_valid),
        .o_flush        (flush),
        .o_running      (running),
        .o_branch_count (branch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk_s(int st, int hl, int fr, int bt, int bpc, int off);
        stim_t s;
        s.start = 1'(st);
        s.halt  = 1'(hl);
        s.fr    = 1'(fr);
        s.bt    = 1'(bt);
        s.bpc   = 8'(bpc);
        s.off   = 8'(off);
        return s;
    endfunction

    function automatic obs_t mk_o(int p, int fv, int fl, int run, int cnt);
        obs_t o;
        o.pc  = 8'(p);
        o.fv  = 1'(fv);
        o.fl  = 1'(fl);
        o.run = 1'(run);
        o.cnt = 8'(cnt);
        return o;
    endfunction

    function automatic obs_t sample();
        return {pc, fetch_valid, flush, running, branch_count};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pc=%h fetch_valid=%b flush=%b running=%b branch_count=%h",
                         o.pc, o.fv, o.fl, o.run, o.cnt);
    endfunction

    task automatic drive(stim_t s);
        start        = s.start;
        halt         = s.halt;
        fetch_ready  = s.fr;
        branch_taken = s.bt;
        branch_pc    = s.bpc;
        offset       = s.off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        drive(mk_s(1, 0, 1, 1, 8'h55, 8'h01));
        rst_n = 1'b0;
        tick();
        tick();
        got = sample();
        want = mk_o(0, 0, 0, 0, 0);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_values: got %s, expected %s", fmt(got), fmt(want));
        end
        drive(mk_s(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        stim_t s[5];
        obs_t  e[5];
        obs_t  got, want;
        s[0] = mk_s(0, 0, 0, 1, 8'h40, 8'h01); e[0] = mk_o(0, 0, 0, 0, 0);
        s[1] = mk_s(1, 0, 1, 0, 0, 0);         e[1] = mk_o(0, 1, 0, 1, 0);
        s[2] = mk_s(0, 0, 1, 0, 0, 0);         e[2] = mk_o(1, 1, 0, 1, 0);
        s[3] = mk_s(0, 0, 1, 0, 0, 0);         e[3] = mk_o(2, 1, 0, 1, 0);
        s[4] = mk_s(0, 0, 1, 0, 0, 0);         e[4] = mk_o(3, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL start[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[6];
        obs_t  e[6];
        obs_t  got, want;
        s[0] = mk_s(0, 0, 1, 0, 0, 0); e[0] = mk_o(4, 1, 0, 1, 0);
        s[1] = mk_s(0, 0, 1, 0, 0, 0); e[1] = mk_o(5, 1, 0, 1, 0);
        s[2] = mk_s(0, 0, 0, 0, 0, 0); e[2] = mk_o(5, 1, 0, 1, 0);
        s[3] = mk_s(1, 0, 0, 0, 0, 0); e[3] = mk_o(5, 1, 0, 1, 0);
        s[4] = mk_s(0, 0, 0, 0, 0, 0); e[4] = mk_o(5, 1, 0, 1, 0);
        s[5] = mk_s(0, 0, 1, 0, 0, 0); e[5] = mk_o(6, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[3];
        obs_t  e[3];
        obs_t  got, want;
        s[0] = mk_s(0, 0, 1, 1, 8'h10, 8'hFE); e[0] = mk_o(8'h0E, 0, 1, 1, 1);
        s[1] = mk_s(0, 0, 1, 1, 8'h40, 8'h01); e[1] = mk_o(8'h0E, 1, 0, 1, 1);
        s[2] = mk_s(0, 0, 1, 0, 0, 0);         e[2] = mk_o(8'h0F, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[7];
        obs_t  e[7];
        obs_t  got, want;
        s[0] = mk_s(0, 0, 0, 1, 8'h00, 8'hFF); e[0] = mk_o(8'hFF, 0, 1, 1, 2);
        s[1] = mk_s(0, 0, 0, 0, 0, 0);         e[1] = mk_o(8'hFF, 1, 0, 1, 2);
        s[2] = mk_s(0, 0, 1, 0, 0, 0);         e[2] = mk_o(8'h00, 1, 0, 1, 2);
        s[3] = mk_s(0, 0, 0, 1, 8'hFF, 8'h01); e[3] = mk_o(8'h00, 0, 1, 1, 3);
        s[4] = mk_s(0, 0, 0, 0, 0, 0);         e[4] = mk_o(8'h00, 1, 0, 1, 3);
        s[5] = mk_s(0, 0, 0, 1, 8'h01, 8'hFE); e[5] = mk_o(8'hFF, 0, 1, 1, 4);
        s[6] = mk_s(0, 0, 0, 0, 0, 0);         e[6] = mk_o(8'hFF, 1, 0, 1, 4);
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_halt_branch();
        stim_t s[4];
        obs_t  e[4];
        obs_t  got, want;
        s[0] = mk_s(0, 0, 1, 0, 0, 0);         e[0] = mk_o(8'h00, 1, 0, 1, 4);
        s[1] = mk_s(0, 1, 1, 1, 8'h20, 8'h01); e[1] = mk_o(8'h00, 0, 0, 0, 4);
        s[2] = mk_s(1, 0, 1, 1, 8'h20, 8'h01); e[2] = mk_o(8'h00, 0, 0, 0, 4);
        s[3] = mk_s(0, 0, 1, 0, 0, 0);         e[3] = mk_o(8'h00, 0, 0, 0, 4);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt_branch[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_async_reset_flush();
        stim_t s[3];
        obs_t  e[3];
        obs_t  got, want;
        rst_n = 1'b0;
        drive(mk_s(0, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        s[0] = mk_s(0, 0, 0, 0, 0, 0);         e[0] = mk_o(8'h00, 0, 0, 0, 0);
        s[1] = mk_s(1, 0, 0, 0, 0, 0);         e[1] = mk_o(8'h00, 1, 0, 1, 0);
        s[2] = mk_s(0, 0, 0, 1, 8'h30, 8'h00); e[2] = mk_o(8'h30, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL async_setup[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = sample();
        want = mk_o(0, 0, 0, 0, 0);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset_mid_flush: got %s, expected %s", fmt(got), fmt(want));
        end
        drive(mk_s(0, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        obs_t got, want;
        int   cnt;
        drive(mk_s(1, 0, 1, 0, 0, 0));
        exp_q.push_back(mk_o(0, 1, 0, 1, 0));
        tick();
        got = sample();
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL sat_start: got %s, expected %s", fmt(got), fmt(want));
        end
        cnt = 0;
        for (int k = 0; k < 520; k++) begin
            drive(mk_s(0, 0, 1, 1, 8'h00, 8'h00));
            if (k % 2 == 0) begin
                if (cnt < 255) cnt++;
                exp_q.push_back(mk_o(0, 0, 1, 1, cnt));
            end else begin
                exp_q.push_back(mk_o(0, 1, 0, 1, cnt));
            end
            tick();
            got = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        drive(mk_s(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        test_reset();
        test_start();
        test_stall();
        test_branch();
        test_wrap();
        test_halt_branch();
        test_async_reset_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
